// File: rtl/score_display_ctrl_pkg.sv
// Shared types and constants for the score display sequencer.
//   digit_idx_t  : scan slot (ONES, TENS, HUNDREDS)
//   conv_state_t : binary-to-BCD conversion FSM state
//   sat_score    : clamps a raw binary score to the displayable maximum
package score_display_pkg;

   localparam int SCORE_W    = 10;
   localparam int SCORE_MAX  = 999;
   localparam int CONV_STEPS = 10;

   typedef enum logic [1:0] {
      ONES     = 2'd0,
      TENS     = 2'd1,
      HUNDREDS = 2'd2
   } digit_idx_t;

   typedef enum logic {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } conv_state_t;

   // Three digits cannot show more than 999, so larger scores are clamped.
   function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
      logic [SCORE_W-1:0] r;
      if (s > SCORE_W'(SCORE_MAX)) r = SCORE_W'(SCORE_MAX);
      else                         r = s;
      return r;
   endfunction

endpackage

// File: rtl/score_display_ctrl_bcd_dd_step.sv
// One combinational double-dabble step: every BCD nibble >= 5 gets +3,
// then the concatenation {bcd, bin} is shifted left by one bit.
//   bcd_in/bcd_out : 3-nibble BCD accumulator before/after the step
//   bin_in/bin_out : remaining binary bits before/after the step
module bcd_dd_step
   import score_display_pkg::*;
(
   input  logic [11:0]        bcd_in,
   input  logic [SCORE_W-1:0] bin_in,
   output logic [11:0]        bcd_out,
   output logic [SCORE_W-1:0] bin_out
);

   logic [11:0] adj_s;

   // Add-3 correction per nibble followed by the joint left shift.
   always_comb begin
      adj_s = bcd_in;
      for (int i = 0; i < 3; i++) begin
         if (bcd_in[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
         else                          adj_s[4*i +: 4] = bcd_in[4*i +: 4];
      end
      bcd_out = {adj_s[10:0], bin_in[SCORE_W-1]};
      bin_out = {bin_in[SCORE_W-2:0], 1'b0};
   end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display sequencer: converts a binary score to three BCD digits with
// an iterative double-dabble engine and scans them onto one shared digit bus.
//   clk, rst           : clock, asynchronous active-high reset
//   score, score_valid : conversion request (score clamped to 999)
//   busy               : conversion in progress
//   bcd_hundreds/tens/ones : committed digits (never intermediate values)
//   digit_sel/bcd/blank    : registered scan outputs (sel bit0 = ones)
module score_display_ctrl
   import score_display_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter bit BLANK_LZ = 1'b1
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] score,
   input  logic               score_valid,
   output logic               busy,
   output logic [3:0]         bcd_hundreds,
   output logic [3:0]         bcd_tens,
   output logic [3:0]         bcd_ones,
   output logic [2:0]         digit_sel,
   output logic [3:0]         digit_bcd,
   output logic               digit_blank
);

   localparam logic [3:0]  LAST_STEP = 4'(CONV_STEPS - 1);
   localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);

   conv_state_t        state_r;
   logic [SCORE_W-1:0] bin_r;
   logic [SCORE_W-1:0] pend_val_r;
   logic               pend_r;
   logic [11:0]        acc_r;
   logic [3:0]         step_r;
   logic [11:0]        acc_nxt_s;
   logic [SCORE_W-1:0] bin_nxt_s;
   logic [SCORE_W-1:0] score_sat_s;

   logic [15:0] presc_r;
   digit_idx_t  idx_r;
   digit_idx_t  idx_eff_s;
   digit_idx_t  idx_nxt_s;
   logic        tick_s;
   logic [2:0]  sel_nxt_s;
   logic [3:0]  bcd_nxt_s;
   logic        blank_nxt_s;

   assign score_sat_s = sat_score(score);

   bcd_dd_step u_step (
      .bcd_in  (acc_r),
      .bin_in  (bin_r),
      .bcd_out (acc_nxt_s),
      .bin_out (bin_nxt_s)
   );

   // Conversion FSM: capture, ten shift steps, commit, optional restart.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         busy         <= 1'b0;
         pend_r       <= 1'b0;
         pend_val_r   <= '0;
         bin_r        <= '0;
         acc_r        <= 12'd0;
         step_r       <= 4'd0;
         bcd_hundreds <= 4'd0;
         bcd_tens     <= 4'd0;
         bcd_ones     <= 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (score_valid) begin
                  bin_r   <= score_sat_s;
                  acc_r   <= 12'd0;
                  step_r  <= 4'd0;
                  state_r <= CONVERT;
                  busy    <= 1'b1;
               end else begin
                  busy    <= 1'b0;
               end
            end
            CONVERT: begin
               bin_r  <= bin_nxt_s;
               acc_r  <= acc_nxt_s;
               step_r <= step_r + 4'd1;
               if (step_r == LAST_STEP) begin
                  bcd_hundreds <= acc_nxt_s[11:8];
                  bcd_tens     <= acc_nxt_s[7:4];
                  bcd_ones     <= acc_nxt_s[3:0];
                  pend_r       <= 1'b0;
                  // A request on the commit edge beats the stored pending one.
                  if (score_valid) begin
                     bin_r  <= score_sat_s;
                     acc_r  <= 12'd0;
                     step_r <= 4'd0;
                  end else if (pend_r) begin
                     bin_r  <= pend_val_r;
                     acc_r  <= 12'd0;
                     step_r <= 4'd0;
                  end else begin
                     state_r <= IDLE;
                     busy    <= 1'b0;
                  end
               end else if (score_valid) begin
                  pend_r     <= 1'b1;
                  pend_val_r <= score_sat_s;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               pend_r  <= 1'b0;
            end
         endcase
      end
   end

   // Scan next-state: prescaler tick, index advance and per-slot outputs.
   always_comb begin
      tick_s = (presc_r == DIV_LAST);
      case (idx_r)
         ONES, TENS, HUNDREDS: idx_eff_s = idx_r;
         default:              idx_eff_s = ONES;
      endcase
      if (tick_s) begin
         case (idx_eff_s)
            ONES:     idx_nxt_s = TENS;
            TENS:     idx_nxt_s = HUNDREDS;
            HUNDREDS: idx_nxt_s = ONES;
            default:  idx_nxt_s = ONES;
         endcase
      end else begin
         idx_nxt_s = idx_eff_s;
      end
      case (idx_nxt_s)
         ONES: begin
            sel_nxt_s   = 3'b001;
            bcd_nxt_s   = bcd_ones;
            blank_nxt_s = 1'b0;
         end
         TENS: begin
            sel_nxt_s   = 3'b010;
            bcd_nxt_s   = bcd_tens;
            blank_nxt_s = BLANK_LZ && (bcd_hundreds == 4'd0) && (bcd_tens == 4'd0);
         end
         HUNDREDS: begin
            sel_nxt_s   = 3'b100;
            bcd_nxt_s   = bcd_hundreds;
            blank_nxt_s = BLANK_LZ && (bcd_hundreds == 4'd0);
         end
         default: begin
            sel_nxt_s   = 3'b001;
            bcd_nxt_s   = bcd_ones;
            blank_nxt_s = 1'b0;
         end
      endcase
   end

   // Scan registers: prescaler, digit index and registered digit bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r     <= 16'd0;
         idx_r       <= ONES;
         digit_sel   <= 3'b001;
         digit_bcd   <= 4'd0;
         digit_blank <= 1'b0;
      end else begin
         if (tick_s) presc_r <= 16'd0;
         else        presc_r <= presc_r + 16'd1;
         idx_r       <= idx_nxt_s;
         digit_sel   <= sel_nxt_s;
         digit_bcd   <= bcd_nxt_s;
         digit_blank <= blank_nxt_s;
      end
   end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl. Two instances share the request
// inputs: dut_a (SCAN_DIV=4, blanking on) and dut_b (SCAN_DIV=1, blanking off).
// Expected digits come from decimal arithmetic on the clamped score; expected
// scan slots come from the count of clock edges since reset release.
module tb_score_display_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] score;
   logic       score_valid;

   logic       busy_a, busy_b;
   logic [3:0] h_a, t_a, o_a, h_b, t_b, o_b;
   logic [2:0] sel_a, sel_b;
   logic [3:0] db_a, db_b;
   logic       bl_a, bl_b;

   int total = 0;
   int bad   = 0;
   int k;

   always #5 clk = ~clk;

   // Edge count since reset release drives the expected scan slot.
   always @(posedge clk or posedge rst) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   score_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
      .clk(clk), .rst(rst), .score(score), .score_valid(score_valid),
      .busy(busy_a), .bcd_hundreds(h_a), .bcd_tens(t_a), .bcd_ones(o_a),
      .digit_sel(sel_a), .digit_bcd(db_a), .digit_blank(bl_a)
   );

   score_display_ctrl #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_b (
      .clk(clk), .rst(rst), .score(score), .score_valid(score_valid),
      .busy(busy_b), .bcd_hundreds(h_b), .bcd_tens(t_b), .bcd_ones(o_b),
      .digit_sel(sel_b), .digit_bcd(db_b), .digit_blank(bl_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int clamp(input int v);
      return (v > 999) ? 999 : v;
   endfunction

   task automatic chk_digits(input string tag, input int v);
      chk({tag, "_hund_a"}, h_a, v / 100);
      chk({tag, "_tens_a"}, t_a, (v / 10) % 10);
      chk({tag, "_ones_a"}, o_a, v % 10);
      chk({tag, "_hund_b"}, h_b, v / 100);
      chk({tag, "_tens_b"}, t_b, (v / 10) % 10);
      chk({tag, "_ones_b"}, o_b, v % 10);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, {busy_a, busy_b}, 0);
      chk_digits(tag, 0);
      chk({tag, "_sel_a"}, sel_a, 1);
      chk({tag, "_sel_b"}, sel_b, 1);
      chk({tag, "_dbcd"}, {db_a, db_b}, 0);
      chk({tag, "_blank"}, {bl_a, bl_b}, 0);
   endtask

   // Single conversion from idle with no further requests.
   task automatic conv(input int val);
      int s;
      s = clamp(val);
      score = 10'(val);
      score_valid = 1'b1;
      cyc();
      score_valid = 1'b0;
      chk("busy_e0", {busy_a, busy_b}, 3);
      for (int e = 1; e <= 10; e++) begin
         cyc();
         if (e < 10) chk("busy_step", {busy_a, busy_b}, 3);
      end
      chk("busy_done", {busy_a, busy_b}, 0);
      chk_digits("conv", s);
   endtask

   // Scan checks while the committed digits stay at h/t/o.
   task automatic scan_chk(input int cycles, input int h, input int t, input int o);
      int slot;
      int dig [3];
      dig[0] = o; dig[1] = t; dig[2] = h;
      for (int c = 0; c < cycles; c++) begin
         cyc();
         slot = (k / 4) % 3;
         chk("scan_sel_a", sel_a, 1 << slot);
         chk("scan_bcd_a", db_a, dig[slot]);
         if (slot == 2)      chk("scan_blank_a", bl_a, (h == 0) ? 1 : 0);
         else if (slot == 1) chk("scan_blank_a", bl_a, (h == 0 && t == 0) ? 1 : 0);
         else                chk("scan_blank_a", bl_a, 0);
         slot = k % 3;
         chk("scan_sel_b", sel_b, 1 << slot);
         chk("scan_bcd_b", db_b, dig[slot]);
         chk("scan_blank_b", bl_b, 0);
      end
   endtask

   // Chain of conversions with random requests; the latest request seen on
   // edges 1..10 of a conversion becomes the next conversion.
   task automatic rand_chain();
      int cur, nxt, convs;
      bit have;
      convs = 0;
      nxt = 0;
      cur = $urandom_range(0, 1023);
      score = 10'(cur);
      score_valid = 1'b1;
      cyc();
      score_valid = 1'b0;
      do begin
         have = 1'b0;
         for (int e = 1; e <= 10; e++) begin
            if (convs < 2 && $urandom_range(0, 3) == 0) begin
               nxt = $urandom_range(0, 1023);
               have = 1'b1;
               score = 10'(nxt);
               score_valid = 1'b1;
            end
            cyc();
            score_valid = 1'b0;
            if (e < 10) chk("rnd_busy", {busy_a, busy_b}, 3);
         end
         chk_digits("rnd", clamp(cur));
         chk("rnd_busy_end", {busy_a, busy_b}, have ? 3 : 0);
         cur = nxt;
         convs++;
      end while (have);
   endtask

   initial begin
      rst = 1'b1;
      score = 10'd0;
      score_valid = 1'b0;
      #1;
      chk_reset_vals("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      conv(999);
      conv(1023);
      conv(7);
      scan_chk(24, 0, 0, 7);

      // Queued requests: 123 at E0, 456 at E3, 789 at E5.
      score = 10'd123;
      score_valid = 1'b1;
      cyc();
      score_valid = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         if (e == 3) begin score = 10'd456; score_valid = 1'b1; end
         if (e == 5) begin score = 10'd789; score_valid = 1'b1; end
         cyc();
         score_valid = 1'b0;
         if (e < 20) chk("q_busy", {busy_a, busy_b}, 3);
         if (e >= 10 && e < 20) chk_digits("q_first", 123);
      end
      chk("q_busy_end", {busy_a, busy_b}, 0);
      chk_digits("q_second", 789);

      conv(456);
      scan_chk(24, 4, 5, 6);

      for (int n = 0; n < 20; n++) rand_chain();

      // Reset in the middle of a conversion of 500.
      conv(999);
      score = 10'd500;
      score_valid = 1'b1;
      cyc();
      score_valid = 1'b0;
      repeat (5) cyc();
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("rst_mid");
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      repeat (15) cyc();
      chk("rst_no_busy", {busy_a, busy_b}, 0);
      chk_digits("rst_no_commit", 0);
      scan_chk(12, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Sequencer for the snake game's three-digit score display. It converts a binary score into three BCD digits with an iterative shift-add-3 (double-dabble) engine, then time-multiplexes those digits onto one shared 7-segment digit bus. It sits between the game-logic score register and the segment decoder, replacing the free-running per-clock digit rotation with a rate-controlled scan. The scan also supports leading-zero blanking.

## Interface
- SCAN_DIV, default 1000: clk cycles per digit slot; legal range 1..65535; 1 advances the digit every cycle.
- BLANK_LZ, default 1: when 1, leading-zero digits are blanked.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- score  in  10  binary score; values above 999 saturate to 999
- score_valid  in  1  one-cycle request to convert `score`
- busy  out  1  conversion in progress
- bcd_hundreds, bcd_tens, bcd_ones  out  4 each  committed BCD digits
- digit_sel  out  3  one-hot active digit: bit0 = ones, bit1 = tens, bit2 = hundreds
- digit_bcd  out  4  BCD value of the active digit
- digit_blank  out  1  active digit must be dark

## Operation
- Conversion FSM has two states, IDLE and CONVERT.
- **Capture:** in IDLE, `score_valid` captures min(score, 999) into a 10-bit shift register. The 12-bit BCD accumulator clears, the step counter clears to 0, and the state moves to CONVERT.
- **Shift steps:** each CONVERT cycle performs one double-dabble step. Add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. The counter increments after each step.
- **Commit:** on the 10th step edge, the post-step nibbles load bcd_hundreds/tens/ones together. The state then returns to IDLE, unless a request is pending.
- **Pending request:** a `score_valid` during CONVERT stores the saturated score in a single pending register and sets a pend flag. A later request overwrites it, so the latest request wins.
- **Restart on commit:** at the commit edge, if pend is set or `score_valid` is high on that edge, the new value is captured. The state stays CONVERT with the counter at 0, and pend clears. `score_valid` on that edge takes priority over the pending value.
- **Committed digits:** bcd_* never show intermediate values.
- **Scan prescaler:** counts 0..SCAN_DIV-1. A tick fires when the prescaler is at SCAN_DIV-1, and the prescaler wraps to 0 on the next edge.
- **Digit index:** a 2-bit index advances 0→1→2→0 on each tick. The value 3 is unreachable and is treated as 0.
- **Scan outputs:** digit_sel, digit_bcd and digit_blank are registered every cycle from the next index and the currently committed digits.
- **Blanking (BLANK_LZ=1):**
  - hundreds is blanked when it is 0;
  - tens is blanked when hundreds and tens are both 0;
  - ones is never blanked.
- **BLANK_LZ=0:** digit_blank is always 0.
- The scan runs continuously and is independent of `busy`.

## Timing
- **Reset values:**
  - FSM = IDLE, busy = 0, pend = 0;
  - bcd_* = 0;
  - prescaler = 0, index = 0;
  - digit_sel = 3'b001, digit_bcd = 0, digit_blank = 0.
- **Conversion latency:** capture edge E0, steps on edges E1..E10, commit at E10.
  - bcd_* show the new value in the cycle after E10.
  - busy is high from after E0 through E10, and low after E10 if there is no restart.
- **Restart:** busy remains high continuously; the next commit is 10 edges later.
- **Scan outputs:** digit_* reflect a commit one cycle after bcd_* update, i.e., the cycle after E11.
- **Digit dwell:** with SCAN_DIV = N, each digit is held for N cycles. The full rotation is 3N cycles.
- **Reset mid-conversion:** the conversion is aborted, the pending request is discarded, and all outputs return to reset values immediately.

## Structure
- Package `score_display_pkg` holds:
  - `digit_idx_t` enum (ONES, TENS, HUNDREDS);
  - `conv_state_t` enum (IDLE, CONVERT);
  - SCORE_W = 10, SCORE_MAX = 999, CONV_STEPS = 10.
- One sub-module, `bcd_dd_step`: a combinational single double-dabble step (add-3 on 3 nibbles plus shift), instantiated once in the FSM datapath.
- The prescaler, index counter and blanking logic stay in the top module.

## Test plan
- **Reset:** hold rst 3 cycles mid-run → every output at its reset value; digit_sel = 001.
- **Single conversion:** score = 999 pulse at E0 → busy high for 10 cycles; bcd = 9/9/9 after E10; busy low.
- **Saturation and blanking:** score = 1023 → 9/9/9. Then score = 7 with BLANK_LZ = 1 → digits 0/0/7; digit_blank high in the hundreds and tens slots only.
- **Queued requests:** 123 at E0, 456 at E3, 789 at E5 →
  - commit 1/2/3 at E10, with an immediate restart;
  - 456 is never committed;
  - 7/8/9 commits at E20;
  - busy is continuous from after E0 through E20.
- **Scan rotation:** SCAN_DIV = 4, digits 4/5/6 → digit_sel sequence 001, 010, 100, each held 4 cycles, with digit_bcd = 6, 5, 4 respectively. SCAN_DIV = 1 → the digit changes every cycle.
- **Reset during conversion:** rst at E5 of a conversion of 500 → bcd stays 0; busy = 0; no commit after rst deasserts.
